// File: rtl/led_code_arbiter.sv
// ============================================================================
// Module   : led_code_arbiter
// Brief    : Round-robin sharing of one status LED between NUM_REQ requesters;
//            each grant shows a blink-code burst. Optional idle heartbeat is
//            built in when LED_ARB_HEARTBEAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_code_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DIV_BIT   = 26,
    parameter int GAP_TICKS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   code,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   done,
    output logic                   led
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] C_LAST_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [3:0]       C_GAP_LOAD = 4'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_BIT-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [3:0]           remain_q, remain_d;
    logic [3:0]           gap_cnt_q, gap_cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 led_q, led_d;

    logic                 tick;
    logic [IDX_W-1:0]     winner;
    logic [3:0]           winner_code;

    // Search upward from the previous winner so every requester gets a turn.
    always_comb begin
        logic found;
        found  = 1'b0;
        winner = last_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    assign winner_code = code[4*int'(winner) +: 4];
    assign tick        = &cnt_q;

    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        state_d   = state_q;
        last_d    = last_q;
        remain_d  = remain_q;
        gap_cnt_d = gap_cnt_q;
        grant_d   = grant_q;
        done_d    = 1'b0;

        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (req != '0) begin
                        last_d          = winner;
                        grant_d         = '0;
                        grant_d[winner] = 1'b1;
                        remain_d        = winner_code;
                        if (winner_code != 4'd0) begin
                            state_d = ON;
                        end else begin
                            state_d   = GAP;
                            gap_cnt_d = C_GAP_LOAD;
                        end
                    end
                end
                ON: begin
                    state_d  = OFF;
                    remain_d = remain_q - 1'b1;
                end
                OFF: begin
                    if (remain_q != 4'd0) begin
                        state_d = ON;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = C_GAP_LOAD;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == 4'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        grant_d = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
`ifdef LED_ARB_HEARTBEAT_EN
        led_d  = (state_d == IDLE) ? cnt_d[DIV_BIT-1] : (state_d == ON);
`else
        led_d  = (state_d == ON);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            state_q   <= IDLE;
            last_q    <= C_LAST_RST;
            remain_q  <= 4'd0;
            gap_cnt_q <= 4'd0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            led_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            last_q    <= last_d;
            remain_q  <= remain_d;
            gap_cnt_q <= gap_cnt_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            led_q     <= led_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign led   = led_q;

endmodule

`default_nettype wire

// File: doc/led_code_arbiter.md
# led_code_arbiter

Shares the board status LED between several test engines. Each requester gets a blink-code burst that identifies it. A free-running prescaler produces the LED time base. Requesters are served round-robin, one complete burst at a time. The block sits between the test-engine status outputs and the LED pin, in place of a direct heartbeat drive.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `DIV_BIT`, 26: prescaler width; one tick every 2^DIV_BIT cycles.
- `GAP_TICKS`, 4: dark ticks appended after each burst (1..15).
- Ports:
  - `clk`  in  1  system clock.
  - `rst`  in  1  synchronous, active-high reset.
  - `req`  in  NUM_REQ  level request per requester.
  - `code`  in  4*NUM_REQ  blink count per requester; requester i uses bits [4i+3:4i].
  - `grant`  out  NUM_REQ  one-hot; the requester currently being displayed.
  - `busy`  out  1  high whenever the FSM is not in IDLE.
  - `done`  out  1  one-cycle pulse when a burst completes.
  - `led`  out  1  LED drive.

## Operation
- Prescaler:
  - `cnt` is DIV_BIT bits wide and increments every cycle, wrapping naturally.
  - `tick` = (`cnt` == all ones). It is a one-cycle pulse.
- FSM states are IDLE, ON, OFF and GAP. All state changes happen only on a tick cycle.
- IDLE:
  - On a tick with `req` != 0, arbitrate.
  - The winner is the first set bit searching upward from `last`+1, modulo NUM_REQ.
  - Load `last` := winner, `grant` := onehot(winner), `remain` := code[winner].
  - Go to ON if `remain` != 0; otherwise go to GAP.
- ON: on a tick, go to OFF and decrement `remain`.
- OFF: on a tick, go to ON if `remain` != 0; otherwise go to GAP with `gap_cnt` := GAP_TICKS-1.
- GAP:
  - On a tick with `gap_cnt` == 0: go to IDLE, pulse `done`, clear `grant`.
  - On any other tick: decrement `gap_cnt`.
- `req` and `code` are sampled only at arbitration. Deasserting `req` mid-burst does not shorten the burst. Changing `code` mid-burst has no effect.
- IDLE waits for the next tick after a burst, so bursts are separated by at least one full tick period in IDLE plus GAP.
- `led` = 1 only in ON, apart from the idle behaviour described in Configuration.
- Reset:
  - `cnt`=0, state=IDLE, `last`=NUM_REQ-1 (so requester 0 has first priority), `remain`=0, `gap_cnt`=0.
  - Outputs: `grant`=0, `busy`=0, `done`=0, `led`=0.
  - Reset asserted mid-burst aborts the burst with no `done` pulse. All outputs are 0 in the cycle after the reset edge.

## Timing
- All outputs are registered.
- Both state and outputs change in the cycle after a tick cycle.
- The first tick occurs at cycle 2^DIV_BIT-1, where cycle 0 is the first cycle with `rst` low. Later ticks follow every 2^DIV_BIT cycles.
- Arbitration latency: `grant`/`busy` rise in the cycle after the first tick that sees `req` != 0.
- Burst duration from `grant` rise to `done` is (2*code + GAP_TICKS) * 2^DIV_BIT cycles.
- `done` is high for exactly one cycle; in that same cycle `grant`=0 and `busy`=0.
- A code of 15 gives 15 blinks; `remain` is 4 bits and never underflows.

## Configuration
- Macro: `LED_ARB_HEARTBEAT_EN`.
- Defined: in IDLE, `led` = `cnt`[DIV_BIT-1], a 50% heartbeat with period 2^DIV_BIT cycles. In ON/OFF/GAP it follows the rules above.
- Undefined: `led` = 0 in IDLE. The heartbeat logic is absent.

## Test plan
All scenarios use DIV_BIT=3 (tick at cycles 7, 15, 23, …), NUM_REQ=4, GAP_TICKS=2, macro undefined unless stated.
- Reset check: hold `rst` 4 cycles with `req`=4'b1111 → `grant`=0, `busy`=0, `done`=0, `led`=0 throughout.
- Single burst: `req`=4'b0001, code0=2 → `grant`=0001 from cycle 8. `led` is high on cycles 8–15 and 24–31, low on 16–23 and 32–55. `done` is high on cycle 56 only, with `grant`=0 on cycle 56.
- Round-robin: hold `req`=4'b1111 with all codes=1 → successive grants 0001, 0010, 0100, 1000, 0001. Each burst is 32 cycles, with 8 idle cycles between bursts.
- Zero code: `req`=4'b0100, code2=0 → `grant`=0100 for 16 cycles, `led` stays 0, `done` pulses once.
- Mid-burst reset: assert `rst` during ON of requester 2 → the next cycle shows `led`=0, `grant`=0, `busy`=0 and no `done`. Then `req`=4'b0101 is granted 0001 first.
- Macro defined: idle with `req`=0 → `led` toggles every 4 cycles (low on cycles 0–3, high on 4–7). During a burst `led` follows ON/OFF/GAP.
